// File: rtl/stage_id_pipe_if.sv
// rtl/stage_id_pipe_if.sv - fetch-side and execute-side signals of the decode stage
interface stage_id_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SRC_W  = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_inst;
    logic [DATA_W-1:0]     in_pc;
    logic [REG_ADDR_W-1:0] regfile_addr1;
    logic [REG_ADDR_W-1:0] regfile_addr2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_pc;
    logic                  out_reg_wr;
    logic [REG_ADDR_W-1:0] out_reg_addr_rd;
    logic [REG_ADDR_W-1:0] out_reg_addr_r1;
    logic [REG_ADDR_W-1:0] out_reg_addr_r2;
    logic [3:0]            out_alu_op;
    logic [ALU_SRC_W-1:0]  out_alu_src_arg1;
    logic [ALU_SRC_W-1:0]  out_alu_src_arg2;
    logic [DATA_W-1:0]     out_imm;
    logic                  out_mem_rd;
    logic                  out_mem_wr;
    logic [2:0]            out_mem_size;
    logic                  out_branch;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, regfile_addr1, regfile_addr2,
        output out_valid, out_pc, out_reg_wr, out_reg_addr_rd, out_reg_addr_r1,
        output out_reg_addr_r2, out_alu_op, out_alu_src_arg1, out_alu_src_arg2,
        output out_imm, out_mem_rd, out_mem_wr, out_mem_size, out_branch, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, regfile_addr1, regfile_addr2,
        input  out_valid, out_pc, out_reg_wr, out_reg_addr_rd, out_reg_addr_r1,
        input  out_reg_addr_r2, out_alu_op, out_alu_src_arg1, out_alu_src_arg2,
        input  out_imm, out_mem_rd, out_mem_wr, out_mem_size, out_branch, out_illegal
    );
endinterface

// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - RV32I decode stage with registered control bundle and load-use interlock
module stage_id_pipe #(
    parameter int DATA_W         = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int ALU_SRC_W      = 2,
    parameter int LOAD_USE_CHECK = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           flush,
    stage_id_pipe_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALU_SRC_W-1:0] SRC_R    = ALU_SRC_W'(0);
    localparam logic [ALU_SRC_W-1:0] SRC_IMM  = ALU_SRC_W'(1);
    localparam logic [ALU_SRC_W-1:0] SRC_PC   = ALU_SRC_W'(2);
    localparam logic [ALU_SRC_W-1:0] SRC_ZERO = ALU_SRC_W'(3);

    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     imm_i;
    logic [DATA_W-1:0]     imm_s;
    logic [DATA_W-1:0]     imm_b;
    logic [DATA_W-1:0]     imm_u;

    assign opcode = bus.in_inst[6:0];
    assign func3  = bus.in_inst[14:12];
    assign func7  = bus.in_inst[31:25];
    assign rd     = REG_ADDR_W'(bus.in_inst[11:7]);
    assign rs1    = REG_ADDR_W'(bus.in_inst[19:15]);
    assign rs2    = REG_ADDR_W'(bus.in_inst[24:20]);

    // Signed casts give sign extension to DATA_W without zero-width replications.
    assign imm_i = DATA_W'($signed(bus.in_inst[31:20]));
    assign imm_s = DATA_W'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
    assign imm_b = DATA_W'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                    bus.in_inst[11:8], 1'b0}));
    assign imm_u = DATA_W'($signed({bus.in_inst[31:12], 12'b0}));

    assign bus.regfile_addr1 = rs1;
    assign bus.regfile_addr2 = rs2;

    logic                 d_writes;
    logic                 d_reg_wr;
    logic [3:0]           d_alu_op;
    logic [ALU_SRC_W-1:0] d_src1;
    logic [ALU_SRC_W-1:0] d_src2;
    logic [DATA_W-1:0]    d_imm;
    logic                 d_mem_rd;
    logic                 d_mem_wr;
    logic [2:0]           d_mem_size;
    logic                 d_branch;
    logic                 d_illegal;
    logic                 uses_rs1;
    logic                 uses_rs2;

    always_comb begin
        d_writes   = 1'b0;
        d_alu_op   = 4'b0000;
        d_src1     = SRC_R;
        d_src2     = SRC_R;
        d_imm      = '0;
        d_mem_rd   = 1'b0;
        d_mem_wr   = 1'b0;
        d_mem_size = 3'b000;
        d_branch   = 1'b0;
        d_illegal  = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_illegal = (func7 != 7'h00) && (func7 != 7'h20);
                d_alu_op  = {func7[5], func3};
                d_writes  = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                d_alu_op = {(func3 == 3'b101) && bus.in_inst[30], func3};
                d_src2   = SRC_IMM;
                d_imm    = imm_i;
                d_writes = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                d_src2     = SRC_IMM;
                d_imm      = imm_i;
                d_mem_rd   = 1'b1;
                d_mem_size = func3;
                d_writes   = 1'b1;
                uses_rs1   = 1'b1;
            end
            OPC_STORE: begin
                d_src2     = SRC_IMM;
                d_imm      = imm_s;
                d_mem_wr   = 1'b1;
                d_mem_size = func3;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OPC_BRANCH: begin
                d_alu_op = {1'b0, func3};
                d_imm    = imm_b;
                d_branch = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LUI: begin
                d_src1   = SRC_ZERO;
                d_src2   = SRC_IMM;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_src1   = SRC_PC;
                d_src2   = SRC_IMM;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign d_reg_wr = d_writes && !d_illegal && (rd != '0);

    // The interlock compares against the load currently held in the output register.
    logic hazard;
    assign hazard = (LOAD_USE_CHECK != 0) && bus.out_valid && bus.out_mem_rd &&
                    (bus.out_reg_addr_rd != '0) &&
                    ((uses_rs1 && (rs1 == bus.out_reg_addr_rd)) ||
                     (uses_rs2 && (rs2 == bus.out_reg_addr_rd)));

    assign bus.in_ready = en && (flush || ((!bus.out_valid || bus.out_ready) && !hazard));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid        <= 1'b0;
            bus.out_pc           <= '0;
            bus.out_reg_wr       <= 1'b0;
            bus.out_reg_addr_rd  <= '0;
            bus.out_reg_addr_r1  <= '0;
            bus.out_reg_addr_r2  <= '0;
            bus.out_alu_op       <= '0;
            bus.out_alu_src_arg1 <= '0;
            bus.out_alu_src_arg2 <= '0;
            bus.out_imm          <= '0;
            bus.out_mem_rd       <= 1'b0;
            bus.out_mem_wr       <= 1'b0;
            bus.out_mem_size     <= '0;
            bus.out_branch       <= 1'b0;
            bus.out_illegal      <= 1'b0;
        end else if (en) begin
            if (!flush && bus.in_valid && bus.in_ready) begin
                bus.out_valid        <= 1'b1;
                bus.out_pc           <= bus.in_pc;
                bus.out_reg_wr       <= d_reg_wr;
                bus.out_reg_addr_rd  <= rd;
                bus.out_reg_addr_r1  <= rs1;
                bus.out_reg_addr_r2  <= rs2;
                bus.out_alu_op       <= d_alu_op;
                bus.out_alu_src_arg1 <= d_src1;
                bus.out_alu_src_arg2 <= d_src2;
                bus.out_imm          <= d_imm;
                bus.out_mem_rd       <= d_mem_rd;
                bus.out_mem_wr       <= d_mem_wr;
                bus.out_mem_size     <= d_mem_size;
                bus.out_branch       <= d_branch;
                bus.out_illegal      <= d_illegal;
            end else if (bus.out_ready || flush) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - directed and randomized checks of stage_id_pipe against a decode model
module tb_stage_id_pipe;
    localparam logic [6:0] OP  = 7'h33;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] LD  = 7'h03;
    localparam logic [6:0] ST  = 7'h23;
    localparam logic [6:0] BR  = 7'h63;
    localparam logic [6:0] LUI = 7'h37;
    localparam logic [6:0] AUI = 7'h17;

    typedef struct packed {
        logic [31:0] pc;
        logic        reg_wr;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [3:0]  alu_op;
        logic [1:0]  src1;
        logic [1:0]  src2;
        logic [31:0] imm;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_size;
        logic        branch;
        logic        illegal;
    } bundle_t;

    logic clk = 1'b0;
    logic rst, en, flush;
    always #5 clk = ~clk;

    stage_id_pipe_if bus ();
    stage_id_pipe dut (.clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus));

    int      checks = 0;
    int      errors = 0;
    logic    m_valid;
    bundle_t m_b;
    logic    obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t model_decode(input logic [31:0] i, input logic [31:0] pc);
        bundle_t b = '0;
        logic [2:0] f3 = i[14:12];
        b.pc = pc;
        b.rd = i[11:7];
        b.r1 = i[19:15];
        b.r2 = i[24:20];
        case (i[6:0])
            OP: begin
                b.illegal = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
                b.alu_op  = {i[30], f3};
                b.reg_wr  = !b.illegal && b.rd != 0;
            end
            OPI: begin
                b.alu_op = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
                b.src2 = 2'd1; b.imm = 32'($signed(i[31:20])); b.reg_wr = b.rd != 0;
            end
            LD: begin
                b.src2 = 2'd1; b.imm = 32'($signed(i[31:20]));
                b.mem_rd = 1'b1; b.mem_size = f3; b.reg_wr = b.rd != 0;
            end
            ST: begin
                b.src2 = 2'd1; b.imm = 32'($signed({i[31:25], i[11:7]}));
                b.mem_wr = 1'b1; b.mem_size = f3;
            end
            BR: begin
                b.alu_op = {1'b0, f3}; b.branch = 1'b1;
                b.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            LUI: begin b.src1 = 2'd3; b.src2 = 2'd1; b.imm = {i[31:12], 12'h000}; b.reg_wr = b.rd != 0; end
            AUI: begin b.src1 = 2'd2; b.src2 = 2'd1; b.imm = {i[31:12], 12'h000}; b.reg_wr = b.rd != 0; end
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    function automatic logic model_ready(input logic [31:0] i, input logic ordy,
                                         input logic fl, input logic e);
        logic u1 = i[6:0] inside {OP, OPI, LD, ST, BR};
        logic u2 = i[6:0] inside {OP, ST, BR};
        logic haz = m_valid && m_b.mem_rd && m_b.rd != 0 &&
                    ((u1 && i[19:15] == m_b.rd) || (u2 && i[24:20] == m_b.rd));
        return e && (fl || ((!m_valid || ordy) && !haz));
    endfunction

    task automatic compare_bundle(input bundle_t e);
        check("out_pc", bus.out_pc, e.pc);
        check("out_reg_wr", 32'(bus.out_reg_wr), 32'(e.reg_wr));
        check("out_reg_addr_rd", 32'(bus.out_reg_addr_rd), 32'(e.rd));
        check("out_reg_addr_r1", 32'(bus.out_reg_addr_r1), 32'(e.r1));
        check("out_reg_addr_r2", 32'(bus.out_reg_addr_r2), 32'(e.r2));
        check("out_alu_op", 32'(bus.out_alu_op), 32'(e.alu_op));
        check("out_alu_src_arg1", 32'(bus.out_alu_src_arg1), 32'(e.src1));
        check("out_alu_src_arg2", 32'(bus.out_alu_src_arg2), 32'(e.src2));
        check("out_imm", bus.out_imm, e.imm);
        check("out_mem_rd", 32'(bus.out_mem_rd), 32'(e.mem_rd));
        check("out_mem_wr", 32'(bus.out_mem_wr), 32'(e.mem_wr));
        check("out_mem_size", 32'(bus.out_mem_size), 32'(e.mem_size));
        check("out_branch", 32'(bus.out_branch), 32'(e.branch));
        check("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered outputs after posedge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic e);
        logic rdy;
        bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc;
        bus.out_ready = ordy; flush = fl; en = e;
        #1;
        rdy = model_ready(inst, ordy, fl, e);
        obs_ready = bus.in_ready;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("regfile_addr1", 32'(bus.regfile_addr1), 32'(inst[19:15]));
        check("regfile_addr2", 32'(bus.regfile_addr2), 32'(inst[24:20]));
        @(posedge clk);
        if (e) begin
            if (fl) m_valid = 1'b0;
            else if (v && rdy) begin m_valid = 1'b1; m_b = model_decode(inst, pc); end
            else if (ordy) m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        compare_bundle(m_b);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i = $urandom;
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1: begin i[6:0] = OP; i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            2: i[6:0] = OP;
            3: i[6:0] = OPI;
            4, 5: i[6:0] = LD;
            6: i[6:0] = ST;
            7: i[6:0] = BR;
            8: i[6:0] = ($urandom_range(0, 1) != 0) ? LUI : AUI;
            default: case ($urandom_range(0, 3))
                0: i[6:0] = 7'h6F;
                1: i[6:0] = 7'h67;
                2: i[6:0] = 7'h73;
                default: i[6:0] = 7'h0F;
            endcase
        endcase
        return i;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
        m_valid = 1'b0; m_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        compare_bundle('0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 32'hFFF10093, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
        check("addi_rd", 32'(bus.out_reg_addr_rd), 32'd1);
        check("addi_r1", 32'(bus.out_reg_addr_r1), 32'd2);
        check("addi_src2", 32'(bus.out_alu_src_arg2), 32'd1);
        check("addi_reg_wr", 32'(bus.out_reg_wr), 32'd1);

        cycle(1'b1, 32'h402081B3, 32'h0000_0104, 1'b1, 1'b0, 1'b1);
        check("sub_alu_op", 32'(bus.out_alu_op), 32'h8);
        check("sub_src2", 32'(bus.out_alu_src_arg2), 32'd0);
        cycle(1'b1, 32'h4030D093, 32'h0000_0108, 1'b1, 1'b0, 1'b1);
        check("srai_no_gap_ready", 32'(obs_ready), 32'd1);
        check("srai_alu_op", 32'(bus.out_alu_op), 32'hD);
        check("srai_src2", 32'(bus.out_alu_src_arg2), 32'd1);

        cycle(1'b1, 32'h0080A283, 32'h0000_0200, 1'b1, 1'b0, 1'b1);
        check("lw_mem_rd", 32'(bus.out_mem_rd), 32'd1);
        check("lw_mem_size", 32'(bus.out_mem_size), 32'd2);
        check("lw_imm", bus.out_imm, 32'd8);
        cycle(1'b1, 32'h00028333, 32'h0000_0204, 1'b1, 1'b0, 1'b1);
        check("load_use_stall", 32'(obs_ready), 32'd0);
        check("load_use_bubble", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 32'h00028333, 32'h0000_0204, 1'b1, 1'b0, 1'b1);
        check("add_after_bubble", 32'(bus.out_valid), 32'd1);
        check("add_rd", 32'(bus.out_reg_addr_rd), 32'd6);

        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h0020E3B3, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
            check("stall_in_ready", 32'(obs_ready), 32'd0);
            check("stall_pc_held", bus.out_pc, 32'h0000_0204);
        end
        cycle(1'b1, 32'h0020E3B3, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
        check("release_handoff", bus.out_pc, 32'h0000_0300);

        cycle(1'b1, 32'hFFF10093, 32'h0000_0400, 1'b1, 1'b1, 1'b1);
        check("flush_kills", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 32'h0000006F, 32'h0000_0404, 1'b1, 1'b0, 1'b1);
        check("jal_illegal", 32'(bus.out_illegal), 32'd1);
        check("jal_reg_wr", 32'(bus.out_reg_wr), 32'd0);
        cycle(1'b1, 32'hFFF10093, 32'h0000_0408, 1'b1, 1'b1, 1'b0);
        check("en_off_ignores_flush", 32'(bus.out_valid), 32'd1);

        bus.in_valid = 1'b1; bus.in_inst = 32'h402081B3; en = 1'b1; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_valid = 1'b0; m_b = '0;
        check("async_reset_valid", 32'(bus.out_valid), 32'd0);
        compare_bundle('0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'hFFF10093, 32'h0000_0500, 1'b1, 1'b0, 1'b1);
        check("after_reset_latency", 32'(bus.out_valid), 32'd1);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) < 8, rand_inst(), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
